// File: rtl/sample_buffer.sv
// Single-port frame buffer: loads one frame of samples, then feeds them one at a time
// under a datafeed_en/yhat_valid handshake. Optional replay: define SAMPLE_BUFFER_REPLAY_EN.
module sample_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9,
  parameter int DEPTH      = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH:0]   frame_len,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  in_ready,
  input  logic                  read_start,
  input  logic                  yhat_valid,
  input  logic                  int_clear,
  input  logic                  replay,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  datafeed_en,
  output logic                  complete,
  output logic [ADDR_WIDTH:0]   fill_count,
  output logic                  overrun
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_WAIT_START = 3'd2,
    S_READ       = 3'd3,
    S_FEED       = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  localparam logic [ADDR_WIDTH:0]   LP_DEPTH  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LP_ZERO_L = (ADDR_WIDTH+1)'(0);
  localparam logic [ADDR_WIDTH:0]   LP_ONE_L  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] LP_ZERO_A = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] LP_ONE_A  = ADDR_WIDTH'(1);

  state_t                r_state;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [ADDR_WIDTH:0]   r_fill_count;
  logic                  r_in_ready;
  logic                  r_datafeed_en;
  logic                  r_complete;
  logic                  r_overrun;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic [DATA_WIDTH-1:0] r_ram [0:DEPTH-1];

  logic [ADDR_WIDTH:0]   w_len_sel;
  logic                  w_wr_en;
  logic                  w_more_s;
  logic                  w_unused_replay;

  assign w_wr_en  = (r_state == S_LOAD) && data_valid && r_in_ready;
  assign w_more_s = ({1'b0, r_rd_addr} < (r_len - LP_ONE_L));

  // A zero or oversized frame length falls back to the full buffer.
  always_comb begin
    w_len_sel = LP_DEPTH;
    if ((frame_len == LP_ZERO_L) || (frame_len > LP_DEPTH)) begin
      w_len_sel = LP_DEPTH;
    end else begin
      w_len_sel = frame_len;
    end
  end

  // Sample storage; never reset, always rewritten before it is read.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_ram[r_wr_addr] <= data_in;
    end
  end

  // Frame control: load, wait, read/feed handshake, completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_len         <= LP_ZERO_L;
      r_wr_addr     <= LP_ZERO_A;
      r_rd_addr     <= LP_ZERO_A;
      r_fill_count  <= LP_ZERO_L;
      r_in_ready    <= 1'b0;
      r_datafeed_en <= 1'b0;
      r_complete    <= 1'b0;
      r_overrun     <= 1'b0;
      r_data_out    <= {DATA_WIDTH{1'b0}};
    end else begin
      if (int_clear) begin
        r_overrun <= 1'b0;
      end else if (data_valid && !r_in_ready) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_len        <= w_len_sel;
          r_wr_addr    <= LP_ZERO_A;
          r_rd_addr    <= LP_ZERO_A;
          r_fill_count <= LP_ZERO_L;
          r_in_ready   <= 1'b1;
          r_state      <= S_LOAD;
        end
        S_LOAD: begin
          if (w_wr_en) begin
            r_wr_addr    <= r_wr_addr + LP_ONE_A;
            r_fill_count <= r_fill_count + LP_ONE_L;
            if (r_fill_count == (r_len - LP_ONE_L)) begin
              r_in_ready <= 1'b0;
              r_state    <= S_WAIT_START;
            end
          end
        end
        S_WAIT_START: begin
          if (read_start) begin
            r_rd_addr <= LP_ZERO_A;
            r_state   <= S_READ;
          end
        end
        S_READ: begin
          r_data_out    <= r_ram[r_rd_addr];
          r_datafeed_en <= 1'b1;
          r_state       <= S_FEED;
        end
        S_FEED: begin
          if (yhat_valid) begin
            r_datafeed_en <= 1'b0;
            if (w_more_s) begin
              r_rd_addr <= r_rd_addr + LP_ONE_A;
              r_state   <= S_READ;
            end else begin
              r_complete <= 1'b1;
              r_state    <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (int_clear) begin
            r_complete <= 1'b0;
            r_state    <= S_IDLE;
`ifdef SAMPLE_BUFFER_REPLAY_EN
          end else if (replay) begin
            r_complete <= 1'b0;
            r_rd_addr  <= LP_ZERO_A;
            r_state    <= S_READ;
`endif
          end
        end
        default: begin
          r_in_ready    <= 1'b0;
          r_datafeed_en <= 1'b0;
          r_complete    <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

  // Without the replay feature the input is accepted but has no effect.
  assign w_unused_replay = replay;

  assign in_ready    = r_in_ready;
  assign data_out    = r_data_out;
  assign datafeed_en = r_datafeed_en;
  assign complete    = r_complete;
  assign fill_count  = r_fill_count;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_sample_buffer.sv
// Directed/randomized bench for sample_buffer: a sample queue holds the expected frame.
module tb_sample_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  frame_len = 10'd0;
  logic        data_valid = 1'b0;
  logic [15:0] data_in = 16'd0;
  logic        in_ready;
  logic        read_start = 1'b0;
  logic        yhat_valid = 1'b0;
  logic        int_clear = 1'b0;
  logic        replay = 1'b0;
  logic [15:0] data_out;
  logic        datafeed_en;
  logic        complete;
  logic [9:0]  fill_count;
  logic        overrun;

  int total = 0;
  int bad   = 0;
  logic [15:0] model[$];

  sample_buffer dut (
    .clk(clk), .rst_n(rst_n), .frame_len(frame_len), .data_valid(data_valid),
    .data_in(data_in), .in_ready(in_ready), .read_start(read_start),
    .yhat_valid(yhat_valid), .int_clear(int_clear), .replay(replay),
    .data_out(data_out), .datafeed_en(datafeed_en), .complete(complete),
    .fill_count(fill_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_datafeed_en"}, 32'(datafeed_en), 32'd0);
    check({tag, "_complete"}, 32'(complete), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
    check({tag, "_fill_count"}, 32'(fill_count), 32'd0);
    check({tag, "_data_out"}, 32'(data_out), 32'd0);
  endtask

  // Writes nwr samples whenever in_ready is high; rdy counts in_ready-high cycles.
  task automatic load_frame(input int nwr, input bit rnd, output int rdy);
    int wr;
    logic [15:0] d;
    wr = 0;
    rdy = 0;
    model.delete();
    for (int c = 0; c < 2000; c++) begin
      if (in_ready) begin
        rdy++;
        if (wr < nwr) begin
          d = rnd ? 16'($urandom) : 16'(32'h11 + wr);
          data_valid = 1'b1;
          data_in = d;
          model.push_back(d);
          wr++;
        end else begin
          data_valid = 1'b0;
        end
      end else begin
        data_valid = 1'b0;
        if (wr == nwr) break;
      end
      tick();
    end
    data_valid = 1'b0;
    check("load_writes", 32'(wr), 32'(nwr));
  endtask

  // Starts the feed (read_start or replay) and consumes every expected sample.
  task automatic feed_frame(input bit via_replay, input int dmin, input int dmax);
    int n;
    int dly;
    n = model.size();
    if (via_replay) replay = 1'b1; else read_start = 1'b1;
    tick();
    replay = 1'b0;
    read_start = 1'b0;
    check("start_n1_en", 32'(datafeed_en), 32'd0);
    check("start_n1_complete", 32'(complete), 32'd0);
    tick();
    for (int i = 0; i < n; i++) begin
      check("feed_en_rise", 32'(datafeed_en), 32'd1);
      check("feed_data", 32'(data_out), 32'(model[i]));
      dly = $urandom_range(dmax, dmin);
      repeat (dly) tick();
      check("feed_hold", 32'(data_out), 32'(model[i]));
      yhat_valid = 1'b1;
      tick();
      yhat_valid = 1'b0;
      check("feed_en_drop", 32'(datafeed_en), 32'd0);
      if (i == n - 1) begin
        check("complete_set", 32'(complete), 32'd1);
      end else begin
        check("complete_early", 32'(complete), 32'd0);
        tick();
      end
    end
  endtask

  initial begin
    int rdy;
    int n_c;

    // Reset state
    #12;
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;

    // Directed 4-sample frame 0x0011..0x0014
    frame_len = 10'd4;
    load_frame(4, 1'b0, rdy);
    check("a_ready_cycles", 32'(rdy), 32'd4);
    check("a_fill", 32'(fill_count), 32'd4);
    check("a_in_ready_low", 32'(in_ready), 32'd0);

    // Write with in_ready low is dropped and flags overrun; stray yhat_valid ignored
    data_valid = 1'b1;
    data_in = 16'hdead;
    tick();
    data_valid = 1'b0;
    check("a_overrun_set", 32'(overrun), 32'd1);
    check("a_fill_kept", 32'(fill_count), 32'd4);
    int_clear = 1'b1;
    yhat_valid = 1'b1;
    tick();
    int_clear = 1'b0;
    yhat_valid = 1'b0;
    check("a_overrun_clr", 32'(overrun), 32'd0);
    check("a_stray_yhat", 32'(datafeed_en), 32'd0);

    feed_frame(1'b0, 3, 3);
    tick();
    tick();
    check("a_complete_held", 32'(complete), 32'd1);
    check("a_data_retained", 32'(data_out), 32'(model[3]));

`ifdef SAMPLE_BUFFER_REPLAY_EN
    feed_frame(1'b1, 3, 3);
`else
    replay = 1'b1;
    tick();
    replay = 1'b0;
    tick();
    tick();
    check("a_replay_ignored_complete", 32'(complete), 32'd1);
    check("a_replay_ignored_en", 32'(datafeed_en), 32'd0);
`endif

    // int_clear beats replay in DONE; frame_len=0 sampled in IDLE means full depth
    frame_len = 10'd0;
    int_clear = 1'b1;
    replay = 1'b1;
    tick();
    int_clear = 1'b0;
    replay = 1'b0;
    check("a_clear_complete", 32'(complete), 32'd0);
    tick();
    check("b_rearm_ready", 32'(in_ready), 32'd1);
    check("b_rearm_en", 32'(datafeed_en), 32'd0);

    load_frame(500, 1'b1, rdy);
    check("b_ready_cycles", 32'(rdy), 32'd500);
    check("b_fill", 32'(fill_count), 32'd500);
    check("b_no_overrun", 32'(overrun), 32'd0);
    data_valid = 1'b1;
    data_in = 16'hbeef;
    tick();
    data_valid = 1'b0;
    check("b_write501_overrun", 32'(overrun), 32'd1);
    check("b_write501_fill", 32'(fill_count), 32'd500);
    feed_frame(1'b0, 0, 2);
    check("b_last_sample", 32'(data_out), 32'(model[499]));

    // Random frame aborted by reset while sample 2 is on the feed
    n_c = $urandom_range(12, 5);
    frame_len = 10'(n_c);
    int_clear = 1'b1;
    tick();
    int_clear = 1'b0;
    load_frame(n_c, 1'b1, rdy);
    check("c_ready_cycles", 32'(rdy), 32'(n_c));
    read_start = 1'b1;
    tick();
    read_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 20; c++) begin
        if (datafeed_en) break;
        tick();
      end
      check("c_en_rise", 32'(datafeed_en), 32'd1);
      check("c_data", 32'(data_out), 32'(model[k]));
      if (k == 0) begin
        yhat_valid = 1'b1;
        tick();
        yhat_valid = 1'b0;
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("c_async_reset");
    tick();
    rst_n = 1'b1;

    // Fresh frame after reset must load from address 0
    frame_len = 10'd3;
    load_frame(3, 1'b1, rdy);
    check("d_ready_cycles", 32'(rdy), 32'd3);
    check("d_fill", 32'(fill_count), 32'd3);
    feed_frame(1'b0, 0, 2);

    // Oversized frame_len falls back to the 500-word depth
    frame_len = 10'd600;
    int_clear = 1'b1;
    tick();
    int_clear = 1'b0;
    load_frame(500, 1'b1, rdy);
    check("e_ready_cycles", 32'(rdy), 32'd500);
    check("e_fill", 32'(fill_count), 32'd500);
    check("e_in_ready_low", 32'(in_ready), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sample_buffer.md
SAMPLE_BUFFER -- requirements
Module: sample_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, sample width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, RAM address width.
REQ-003 SHALL have parameter DEPTH, default 500, RAM words; DEPTH <= 2^ADDR_WIDTH.
REQ-004 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port frame_len, input, ADDR_WIDTH+1, samples per frame, sampled in IDLE.
REQ-007 SHALL have port data_valid, input, 1, write strobe for data_in.
REQ-008 SHALL have port data_in, input, DATA_WIDTH, sample to store.
REQ-009 SHALL have port in_ready, output, 1, buffer accepts a sample this cycle.
REQ-010 SHALL have port read_start, input, 1, begin feeding stored frame.
REQ-011 SHALL have port yhat_valid, input, 1, downstream has consumed the current sample.
REQ-012 SHALL have port int_clear, input, 1, acknowledge completion and rearm.
REQ-013 SHALL have port replay, input, 1, re-feed stored frame (used only with SAMPLE_BUFFER_REPLAY_EN).
REQ-014 SHALL have port data_out, output, DATA_WIDTH, current sample, valid while datafeed_en=1.
REQ-015 SHALL have port datafeed_en, output, 1, data_out valid for downstream.
REQ-016 SHALL have port complete, output, 1, whole frame fed.
REQ-017 SHALL have port fill_count, output, ADDR_WIDTH+1, samples written this frame.
REQ-018 SHALL have port overrun, output, 1, sticky: data_valid arrived while in_ready=0.

Function
REQ-019 SHALL implement states IDLE, LOAD, WAIT_START, READ, FEED, DONE; all outputs registered.
REQ-020 IDLE: latch len = frame_len, except frame_len=0 or >DEPTH gives len=DEPTH; clear wr/rd addresses and fill_count; go to LOAD next cycle.
REQ-021 LOAD: in_ready=1; each cycle with data_valid=1 SHALL write data_in to ram[wr_addr] and increment wr_addr and fill_count -- one sample per cycle, no bubbles.
REQ-022 The write of sample len-1 SHALL move to WAIT_START; in_ready=0 from the next cycle.
REQ-023 data_valid with in_ready=0 SHALL be ignored (no write) and SHALL set overrun.
REQ-024 WAIT_START: read_start=1 moves to READ with rd_addr=0; read_start in any other state is ignored.
REQ-025 READ: one-cycle synchronous RAM read into the data_out register; then FEED.
REQ-026 FEED: datafeed_en=1 with data_out stable; if read_start is sampled at cycle N, datafeed_en rises at N+2.
REQ-027 yhat_valid in FEED at cycle M: datafeed_en=0 at M+1; if rd_addr<len-1, increment rd_addr, go to READ, and raise datafeed_en again at M+2; else go to DONE with complete=1 at M+1.
REQ-028 yhat_valid outside FEED SHALL be ignored.
REQ-029 DONE: complete held at 1 until int_clear=1, then IDLE with complete=0 next cycle; RAM contents are not cleared.
REQ-030 int_clear SHALL also clear overrun in any state; in DONE int_clear has priority over replay.
REQ-031 data_out SHALL retain its last value outside FEED.

Reset
REQ-032 rst_n=0 SHALL asynchronously force: state IDLE, in_ready 0, datafeed_en 0, complete 0, overrun 0, fill_count 0, data_out 0, and all addresses 0.
REQ-033 Reset mid-LOAD or mid-FEED SHALL abort the frame; RAM contents are undefined after reset and never read before rewrite.

Configuration
REQ-034 With macro SAMPLE_BUFFER_REPLAY_EN defined: replay=1 in DONE (int_clear=0) SHALL clear complete, set rd_addr=0 and go to READ, re-feeding the stored frame without reload.
REQ-035 Without SAMPLE_BUFFER_REPLAY_EN: replay is ignored and DONE exits only through int_clear.

Verification
REQ-036 Reset, then frame_len=4 and data_valid=1 for 4 consecutive cycles with data 0x0011..0x0014 -> in_ready high exactly 4 cycles, fill_count=4, state WAIT_START.
REQ-037 read_start pulse, with yhat_valid answered 3 cycles after each datafeed_en rise -> data_out sequence 0x0011..0x0014, complete=1 one cycle after the 4th yhat_valid; int_clear -> complete=0.
REQ-038 frame_len=0 -> 500 writes accepted; write 501 sets overrun; last fed sample equals the 500th written.
REQ-039 rst_n low during FEED of sample 2 -> all outputs 0 immediately; next frame loads from address 0.
REQ-040 With SAMPLE_BUFFER_REPLAY_EN, replay in DONE -> identical 4-sample feed; without it -> complete stays 1.
